// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared types and constants for the RAM port arbiter.
//   - state_t    : burst sequencer states
//   - req_id_t   : requester id (REQ_FETCH / REQ_SREAD / REQ_SWRITE)
//   - line_t     : 256-bit line viewed as 16 words, element [15] = bits [255:240]
//   - clamp_words: limits a requested word count to MAX_WORDS
package ram_port_arbiter_pkg;

  localparam int WORD_W    = 16;
  localparam int LINE_W    = 256;
  localparam int MAX_WORDS = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_TAIL,
    WR,
    DONE
  } state_t;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_FETCH  = 2'd0;
  localparam req_id_t REQ_SREAD  = 2'd1;
  localparam req_id_t REQ_SWRITE = 2'd2;

  typedef logic [MAX_WORDS-1:0][WORD_W-1:0] line_t;

  function automatic logic [4:0] clamp_words(input logic [4:0] words);
    return (words > 5'(MAX_WORDS)) ? 5'(MAX_WORDS) : words;
  endfunction

endpackage

// File: rtl/ram_port_grant_sel.sv
// ram_port_grant_sel
//   Combinational grant selection between the three requesters.
//   Macro RAM_PORT_ARBITER_RR_EN:
//     defined   - round robin; the last granted requester is lowest priority
//                 (last_grant = REQ_FETCH gives swrite > sread > fetch)
//     undefined - fixed priority swrite > sread > fetch; last_grant ignored
//   Ports:
//     fetch_start, sread_start, swrite_start : request levels
//     last_grant : id of the most recently granted requester
//     grant      : one-hot grant, bit index = requester id ('0 when none)
module ram_port_grant_sel
  import ram_port_arbiter_pkg::*;
(
  input  logic    fetch_start,
  input  logic    sread_start,
  input  logic    swrite_start,
  input  req_id_t last_grant,
  output logic [2:0] grant
);

  logic [2:0] req;
  assign req = {swrite_start, sread_start, fetch_start};

`ifdef RAM_PORT_ARBITER_RR_EN
  // Priority walks downward from the id just below last_grant, wrapping.
  always_comb begin
    grant = '0;
    case (last_grant)
      REQ_SREAD: begin
        if      (req[REQ_FETCH])  grant[REQ_FETCH]  = 1'b1;
        else if (req[REQ_SWRITE]) grant[REQ_SWRITE] = 1'b1;
        else if (req[REQ_SREAD])  grant[REQ_SREAD]  = 1'b1;
      end
      REQ_SWRITE: begin
        if      (req[REQ_SREAD])  grant[REQ_SREAD]  = 1'b1;
        else if (req[REQ_FETCH])  grant[REQ_FETCH]  = 1'b1;
        else if (req[REQ_SWRITE]) grant[REQ_SWRITE] = 1'b1;
      end
      default: begin
        if      (req[REQ_SWRITE]) grant[REQ_SWRITE] = 1'b1;
        else if (req[REQ_SREAD])  grant[REQ_SREAD]  = 1'b1;
        else if (req[REQ_FETCH])  grant[REQ_FETCH]  = 1'b1;
      end
    endcase
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant = '0;
    if      (req[REQ_SWRITE]) grant[REQ_SWRITE] = 1'b1;
    else if (req[REQ_SREAD])  grant[REQ_SREAD]  = 1'b1;
    else if (req[REQ_FETCH])  grant[REQ_FETCH]  = 1'b1;
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port 16-bit RAM between instruction fetch, stack read
//   and stack write. Each grant runs a burst of 0..16 words; reads are packed
//   MSB-first into rdata, writes are unpacked MSB-first from swrite_data.
//   Optional macro RAM_PORT_ARBITER_RR_EN selects round-robin grant priority
//   (see ram_port_grant_sel); default is fixed swrite > sread > fetch.
//   Ports:
//     clock, reset                  : rising-edge clock, sync active-high reset
//     <req>_start/_address/_words   : request level, base word address, count
//     <req>_done                    : held while the granted start stays high
//     swrite_data                   : write source, word i at [255-16i -: 16]
//     rdata                         : read result, word i at [255-16i -: 16]
//     mem_addr/re/we/wdata, mem_rdata : RAM port, read data 1 cycle after re
//     busy                          : high whenever not IDLE
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] fetch_address,
  input  logic [4:0]        fetch_words,
  output logic              fetch_done,
  input  logic              sread_start,
  input  logic [ADDR_W-1:0] sread_address,
  input  logic [4:0]        sread_words,
  output logic              sread_done,
  input  logic              swrite_start,
  input  logic [ADDR_W-1:0] swrite_address,
  input  logic [4:0]        swrite_words,
  input  logic [LINE_W-1:0] swrite_data,
  output logic              swrite_done,
  output logic [LINE_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  req_id_t           grant_id_q, last_grant_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        count_q;
  logic [4:0]        idx_q;
  logic              rd_valid_q;
  logic [3:0]        rd_slot_q;
  line_t             rd_words_q;
  line_t             src_line;

  logic [2:0]        grant;
  req_id_t           sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [4:0]        sel_count;
  logic              granted_start;
  logic              last_word;

  ram_port_grant_sel u_grant_sel (
    .fetch_start  (fetch_start),
    .sread_start  (sread_start),
    .swrite_start (swrite_start),
    .last_grant   (last_grant_q),
    .grant        (grant)
  );

  assign src_line = swrite_data;
  assign rdata    = rd_words_q;

  always_comb begin
    sel_id    = REQ_FETCH;
    sel_addr  = fetch_address;
    sel_count = clamp_words(fetch_words);
    if (grant[REQ_SWRITE]) begin
      sel_id    = REQ_SWRITE;
      sel_addr  = swrite_address;
      sel_count = clamp_words(swrite_words);
    end else if (grant[REQ_SREAD]) begin
      sel_id    = REQ_SREAD;
      sel_addr  = sread_address;
      sel_count = clamp_words(sread_words);
    end
  end

  always_comb begin
    case (grant_id_q)
      REQ_SREAD:  granted_start = sread_start;
      REQ_SWRITE: granted_start = swrite_start;
      default:    granted_start = fetch_start;
    endcase
  end

  assign last_word = (idx_q == count_q - 5'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          if (sel_count == 5'd0)        state_d = DONE;
          else if (sel_id == REQ_SWRITE) state_d = WR;
          else                           state_d = RD;
        end
      end
      RD:      if (last_word) state_d = RD_TAIL;
      RD_TAIL: state_d = DONE;
      WR:      if (last_word) state_d = DONE;
      DONE:    if (!granted_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = (state_q != IDLE);
    fetch_done  = 1'b0;
    sread_done  = 1'b0;
    swrite_done = 1'b0;
    case (state_q)
      RD: begin
        mem_re   = 1'b1;
        mem_addr = base_q + {{(ADDR_W-5){1'b0}}, idx_q};
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + {{(ADDR_W-5){1'b0}}, idx_q};
        mem_wdata = src_line[~idx_q[3:0]];
      end
      DONE: begin
        fetch_done  = (grant_id_q == REQ_FETCH);
        sread_done  = (grant_id_q == REQ_SREAD);
        swrite_done = (grant_id_q == REQ_SWRITE);
      end
      default: ;
    endcase
  end

  // Read data lags its strobe by one cycle, so the word index travels with a
  // valid flag and is captured one edge later; RD_TAIL exists only to let the
  // final word land before DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_id_q   <= REQ_FETCH;
      last_grant_q <= REQ_FETCH;
      base_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_slot_q    <= '0;
      rd_words_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= (state_q == RD);
      rd_slot_q  <= idx_q[3:0];
      if (rd_valid_q) rd_words_q[~rd_slot_q] <= mem_rdata;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            grant_id_q   <= sel_id;
            last_grant_q <= sel_id;
            base_q       <= sel_addr;
            count_q      <= sel_count;
            idx_q        <= '0;
            if (sel_id != REQ_SWRITE) rd_words_q <= '0;
          end
        end
        RD, WR:  idx_q <= idx_q + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port, 16-bit-word RAM between three requesters: instruction fetch, stack read and stack write.
- Each requester uses a level start/done handshake. The arbiter grants one requester at a time and sequences it as a burst of 1..16 words.
- Read bursts are packed MSB-first into a 256-bit result. Write bursts are unpacked from a 256-bit source.
- Sits between the CPU control FSM and the RAM; replaces the separate per-requester read/write models.

Parameters:
- MAX_WORDS, 16, burst length cap; fixed at 16 = 256/16.
- ADDR_W, 16, word address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- fetch_start  in  1  fetch request level; held until fetch_done is seen
- fetch_address  in  16  fetch start word address
- fetch_words  in  5  fetch word count
- fetch_done  out  1  fetch complete; held while fetch_start stays high
- sread_start / sread_address / sread_words / sread_done  in/in/in/out  1/16/5/1  stack read requester, same rules as fetch
- swrite_start / swrite_address / swrite_words / swrite_done  in/in/in/out  1/16/5/1  stack write requester, same rules
- swrite_data  in  256  write source; word i taken from bits [255-16i -: 16]
- rdata  out  256  read result; word i at bits [255-16i -: 16]
- mem_addr  out  16  RAM word address
- mem_re  out  1  RAM read strobe; mem_rdata is valid the cycle after
- mem_we  out  1  RAM write strobe
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, 1-cycle latency
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all done signals 0, mem_re 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, busy 0, state IDLE.
- Reset mid-burst aborts the burst with no further strobes; the requester must re-issue.
- States: IDLE, RD, RD_TAIL, WR, DONE.
- IDLE:
  - Samples the three start signals. Fixed priority: swrite > sread > fetch.
  - Latches the winner's address and count. A count of 0 is legal; a count above 16 clamps to 16.
  - On a read grant, clears rdata to 0.
  - Count 0 goes straight to DONE. Otherwise the winner goes to RD (reads) or WR (writes).
- RD:
  - One word per cycle: mem_re=1, mem_addr=base+i, i=0..N-1.
  - Data returned for word i is written into rdata word i on the following edge.
  - After word N-1 is issued, go to RD_TAIL. RD_TAIL captures the last word, then goes to DONE.
- WR:
  - One word per cycle: mem_we=1, mem_addr=base+i, mem_wdata=word i of swrite_data.
  - swrite_data must stay stable until swrite_done.
  - After word N-1, go to DONE.
- DONE:
  - Asserts the granted requester's done only; the other dones stay 0.
  - Holds done until that requester's start is sampled low. Then done drops to 0 and the state returns to IDLE on the same edge.
  - A new grant can therefore occur on the next edge at the earliest.
- Latency from the edge where IDLE samples start:
  - Read: first strobe in cycle 1, done high from cycle N+2.
  - Write: done high from cycle N+1.
  - Count 0: done high from cycle 1.
- rdata holds its value until the next read grant. Unfilled words are 0.
- Address arithmetic is 16-bit with wrap: base 0xFFFF with 2 words accesses 0xFFFF, then 0x0000.
- mem_re and mem_we are never high in the same cycle. Both are 0 in IDLE and DONE.
- A requester dropping start mid-burst is a protocol violation. The burst still completes and done pulses for one cycle.
- Requests not granted stay pending; start held high is simply re-sampled in IDLE.

Optional Feature:
- Macro: RAM_PORT_ARBITER_RR_EN
- Defined: round-robin priority. The requester granted last becomes lowest priority. After reset the order is swrite > sread > fetch.
- Undefined: fixed priority swrite > sread > fetch; starvation of fetch under continuous stack traffic is accepted.

Decomposition:
- Shared package: state enum (IDLE, RD, RD_TAIL, WR, DONE), requester id encoding (REQ_FETCH=0, REQ_SREAD=1, REQ_SWRITE=2), WORD_W=16, LINE_W=256, MAX_WORDS=16.
- One sub-module: ram_port_grant_sel, combinational. Inputs: three start bits and last-grant id. Output: one-hot grant. Holds both the fixed and round-robin policy.
- Burst sequencing and packing stay in the top module.

Test Plan:
- Fetch, address 0x0010, 4 words, RAM[0x10..0x13] = 1,2,3,4 -> mem_re in cycles 1..4; fetch_done from cycle 6; rdata[255:192] = 0x0001_0002_0003_0004; rest of rdata 0.
- swrite, address 0x0100, 2 words, swrite_data[255:224] = 0xAAAA_5555 -> mem_we in cycles 1..2 at 0x0100/0x0101 with data AAAA/5555; swrite_done from cycle 3.
- fetch and sread raised on the same edge -> sread granted first; fetch done only after sread start drops. With RR_EN and fetch/sread contending back-to-back, grants alternate.
- sread count 0 -> no strobes; sread_done in cycle 1; rdata = 0. Count 20 -> exactly 16 reads.
- Read at 0xFFFF, 2 words -> mem_addr 0xFFFF, then 0x0000.
- reset asserted in cycle 2 of an 8-word write -> next cycle mem_we=0, all done=0, busy=0; a re-issued request completes normally.
